// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, sequencer states and flag bit positions shared by the ALU and its sequencer
package alu_pkg;
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_LAND = 4'd6;
    localparam logic [3:0] OP_LOR  = 4'd7;
    localparam logic [3:0] OP_LXOR = 4'd8;
    localparam logic [3:0] OP_LNOT = 4'd9;
    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;
    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_RESP} state_t;
endpackage

// File: rtl/full_adder.sv
// full_adder: combinational 8-bit ALU; SUB computes a-b-cin with carry meaning borrow
module full_adder
    import alu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] opcode,
    input  logic       cin,
    output logic [7:0] result,
    output logic       zero,
    output logic       carry,
    output logic       overflow,
    output logic       negative
);
    logic [8:0] sum, dif;
    always_comb begin
        sum = {1'b0, a} + {1'b0, b} + {8'h00, cin};
        dif = {1'b0, a} - {1'b0, b} - {8'h00, cin};
        case (opcode)
            OP_ADD:  result = sum[7:0];
            OP_SUB:  result = dif[7:0];
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_LAND: result = {7'h00, |a && |b};
            OP_LOR:  result = {7'h00, |a || |b};
            OP_LXOR: result = {7'h00, |a ^ |b};
            OP_LNOT: result = {7'h00, ~|a};
            default: result = 8'h00;
        endcase
        carry    = opcode == OP_ADD ? sum[8] : opcode == OP_SUB ? dif[8] : 1'b0;
        overflow = opcode == OP_ADD ? (a[7] == b[7]) && (result[7] != a[7]) :
                   opcode == OP_SUB ? (a[7] != b[7]) && (result[7] != a[7]) : 1'b0;
        zero     = result == 8'h00;
        negative = result[7];
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: runs 8-bit or chained 16-bit (ADD/SUB) ops on one ALU with a valid/ready handshake
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NUM_OPS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic        req_wide,
    input  logic        req_use_c,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_result,
    output logic        resp_err,
    output logic [3:0]  flags_q
);
    state_t      state_q;
    logic [3:0]  op_q;
    logic        wide_q, use_c_q, lo_c_q;
    logic [15:0] a_q, b_q;
    logic [7:0]  lo_q;
    logic [7:0]  alu_a, alu_b, alu_r;
    logic [3:0]  alu_op;
    logic        alu_cin, alu_z, alu_c, alu_v, alu_n, illegal_d;

    assign req_ready = state_q == S_IDLE;
    assign illegal_d = 32'(req_op) >= NUM_OPS || (req_wide && req_op != OP_ADD && req_op != OP_SUB);

    // ALU sees zeros outside the two active passes
    always_comb begin
        alu_a   = state_q == S_LO ? a_q[7:0] : state_q == S_HI ? a_q[15:8] : 8'h00;
        alu_b   = state_q == S_LO ? b_q[7:0] : state_q == S_HI ? b_q[15:8] : 8'h00;
        alu_op  = state_q == S_LO || state_q == S_HI ? op_q : OP_ADD;
        alu_cin = state_q == S_LO ? use_c_q & flags_q[FLAG_C] : state_q == S_HI ? lo_c_q : 1'b0;
    end

    full_adder u_alu (
        .a(alu_a), .b(alu_b), .opcode(alu_op), .cin(alu_cin),
        .result(alu_r), .zero(alu_z), .carry(alu_c), .overflow(alu_v), .negative(alu_n)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            wide_q      <= 1'b0;
            use_c_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            lo_q        <= '0;
            lo_c_q      <= 1'b0;
            flags_q     <= '0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_result <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    op_q    <= req_op;
                    wide_q  <= req_wide;
                    use_c_q <= req_use_c;
                    a_q     <= req_a;
                    b_q     <= req_b;
                    if (illegal_d) begin
                        state_q     <= S_RESP;
                        resp_valid  <= 1'b1;
                        resp_err    <= 1'b1;
                        resp_result <= '0;
                    end else begin
                        state_q <= S_LO;
                    end
                end
                S_LO: if (wide_q) begin
                    lo_q    <= alu_r;
                    lo_c_q  <= alu_c;
                    state_q <= S_HI;
                end else begin
                    resp_result <= {8'h00, alu_r};
                    flags_q     <= {alu_z, alu_c, alu_v, alu_n};
                    resp_valid  <= 1'b1;
                    resp_err    <= 1'b0;
                    state_q     <= S_RESP;
                end
                S_HI: begin
                    resp_result <= {alu_r, lo_q};
                    flags_q     <= {alu_z && lo_q == 8'h00, alu_c, alu_v, alu_n};
                    resp_valid  <= 1'b1;
                    resp_err    <= 1'b0;
                    state_q     <= S_RESP;
                end
                default: if (resp_ready) begin
                    resp_valid <= 1'b0;
                    state_q    <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors checked against literals and a 16-bit arithmetic reference model
module tb_alu_sequencer;
    import alu_pkg::*;

    typedef struct packed {
        logic [15:0] r;
        logic        e;
        logic [3:0]  f;
        logic [1:0]  lat;
    } exp_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        req_valid = 1'b0, req_wide = 1'b0, req_use_c = 1'b0, resp_ready = 1'b1;
    logic [3:0]  req_op = '0;
    logic [15:0] req_a = '0, req_b = '0;
    logic        req_ready, resp_valid, resp_err;
    logic [15:0] resp_result;
    logic [3:0]  flags_q;

    exp_t        m_p = '0;
    logic        m_busy = 1'b0, m_valid = 1'b0;
    logic [3:0]  m_flags = '0;
    int          m_wait = 0;
    int          checks = 0, errors = 0;
    bit          started = 1'b0;

    alu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_wide(req_wide), .req_use_c(req_use_c),
        .req_a(req_a), .req_b(req_b), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .resp_err(resp_err), .flags_q(flags_q)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-width arithmetic: a wide op is just a 16-bit add/subtract
    function automatic exp_t model(input logic [3:0] op, input logic w, input logic uc,
                                   input logic [15:0] a, input logic [15:0] b, input logic [3:0] fl);
        exp_t x;
        int msk, top, sa, sb, ci, s;
        logic c, v;
        x.f = fl;
        x.e = 1'b0;
        x.r = '0;
        x.lat = w ? 2'd3 : 2'd2;
        if (op >= 4'd10 || (w && op > 4'd1)) begin
            x.e = 1'b1;
            x.lat = 2'd1;
            return x;
        end
        msk = w ? 32'hFFFF : 32'hFF;
        top = w ? 15 : 7;
        sa = int'(a) & msk;
        sb = int'(b) & msk;
        ci = uc ? int'(fl[2]) : 0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'd0: begin s = sa + sb + ci; c = s > msk; end
            4'd1: begin s = sa - sb - ci; c = s < 0; end
            4'd2: s = sa & sb;
            4'd3: s = sa | sb;
            4'd4: s = sa ^ sb;
            4'd5: s = ~sa;
            4'd6: s = int'(sa != 0 && sb != 0);
            4'd7: s = int'(sa != 0 || sb != 0);
            4'd8: s = int'((sa != 0) != (sb != 0));
            default: s = int'(sa == 0);
        endcase
        s = s & msk;
        if (op == 4'd0) v = sa[top] == sb[top] && s[top] != sa[top];
        if (op == 4'd1) v = sa[top] != sb[top] && s[top] != sa[top];
        x.r = 16'(s);
        x.f = {s == 0, c, v, s[top] == 1'b1};
        return x;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_n) begin
            m_busy = 1'b0;
            m_valid = 1'b0;
            m_flags = '0;
        end else if (m_valid) begin
            if (resp_ready) begin
                m_valid = 1'b0;
                m_busy = 1'b0;
            end
        end else if (m_busy) begin
            m_wait--;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_flags = m_p.f;
            end
        end else if (req_valid) begin
            m_p = model(req_op, req_wide, req_use_c, req_a, req_b, m_flags);
            m_busy = 1'b1;
            m_wait = int'(m_p.lat) - 1;
            if (m_wait == 0) begin
                m_valid = 1'b1;
                m_flags = m_p.f;
            end
        end
    end

    always @(negedge clk) if (started) begin
        chk("ready", 32'(req_ready), 32'(!m_busy));
        chk("valid", 32'(resp_valid), 32'(m_valid));
        chk("flags", 32'(flags_q), 32'(m_flags));
        if (m_valid) begin
            chk("result", 32'(resp_result), 32'(m_p.r));
            chk("err", 32'(resp_err), 32'(m_p.e));
        end
    end

    task automatic send(input logic [3:0] op, input logic w, input logic uc, input logic [15:0] a,
                        input logic [15:0] b, input int lat, input logic [15:0] er,
                        input logic ee, input logic [3:0] ef);
        int n;
        @(negedge clk);
        req_op = op;
        req_wide = w;
        req_use_c = uc;
        req_a = a;
        req_b = b;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        n = 1;
        while (!resp_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        chk("result_lit", 32'(resp_result), 32'(er));
        chk("err_lit", 32'(resp_err), 32'(ee));
        chk("flags_lit", 32'(flags_q), 32'(ef));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_flags", 32'(flags_q), 32'd0);
        chk("rst_result", 32'(resp_result), 32'd0);
        rst_n = 1'b1;
        started = 1'b1;
        send(OP_ADD,  1'b0, 1'b0, 16'h007F, 16'h0001, 2, 16'h0080, 1'b0, 4'b0011);
        send(OP_ADD,  1'b1, 1'b0, 16'h00FF, 16'h0001, 3, 16'h0100, 1'b0, 4'b0000);
        send(OP_SUB,  1'b1, 1'b0, 16'h0100, 16'h0001, 3, 16'h00FF, 1'b0, 4'b0000);
        send(OP_ADD,  1'b0, 1'b0, 16'd200,  16'd100,  2, 16'h002C, 1'b0, 4'b0100);
        send(4'hC,    1'b0, 1'b0, 16'h0001, 16'h0001, 1, 16'h0000, 1'b1, 4'b0100);
        send(OP_AND,  1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1, 16'h0000, 1'b1, 4'b0100);
        send(OP_ADD,  1'b0, 1'b1, 16'h0000, 16'h0000, 2, 16'h0001, 1'b0, 4'b0000);
        send(OP_AND,  1'b0, 1'b0, 16'hF0F0, 16'h3C3C, 2, 16'h0030, 1'b0, 4'b0000);
        send(OP_NOT,  1'b0, 1'b0, 16'h0055, 16'h0000, 2, 16'h00AA, 1'b0, 4'b0001);
        send(OP_LNOT, 1'b0, 1'b0, 16'h0000, 16'h0000, 2, 16'h0001, 1'b0, 4'b0000);
        send(OP_SUB,  1'b1, 1'b0, 16'h8000, 16'h0001, 3, 16'h7FFF, 1'b0, 4'b0010);
        send(OP_ADD,  1'b1, 1'b0, 16'hFFFF, 16'h0001, 3, 16'h0000, 1'b0, 4'b1100);
        send(OP_ADD,  1'b1, 1'b1, 16'h1234, 16'h0001, 3, 16'h1236, 1'b0, 4'b0000);
        @(negedge clk);
        resp_ready = 1'b0;
        send(OP_SUB,  1'b0, 1'b0, 16'h0005, 16'h0007, 2, 16'h00FE, 1'b0, 4'b0101);
        req_op = OP_ADD;
        req_wide = 1'b0;
        req_use_c = 1'b0;
        req_a = 16'h0001;
        req_b = 16'h0001;
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_result", 32'(resp_result), 32'h00FE);
            chk("bp_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp_release_valid", 32'(resp_valid), 32'd0);
        chk("bp_release_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        chk("bp_not_taken", 32'(resp_valid), 32'd0);
        req_op = OP_ADD;
        req_wide = 1'b1;
        req_a = 16'h1111;
        req_b = 16'h2222;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("hi_busy", 32'(req_ready), 32'd0);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_valid", 32'(resp_valid), 32'd0);
        chk("abort_flags", 32'(flags_q), 32'd0);
        repeat (2) @(negedge clk);
        chk("abort_no_resp", 32'(resp_valid), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous active-low reset: clk  in  1  rising-edge clock; rst_n  in  1  synchronous active-low reset.
REQ-002 The block SHALL have these request ports: req_valid  in  1  request present; req_ready  out  1  block can accept; req_op  in  4  ALU opcode 0-9; req_wide  in  1  16-bit two-pass op; req_use_c  in  1  cin = stored C flag; req_a  in  16  operand A; req_b  in  16  operand B.
REQ-003 The block SHALL have these response ports: resp_valid  out  1  response present; resp_ready  in  1  consumer accepts; resp_result  out  16  result; resp_err  out  1  illegal request; flags_q  out  4  stored flags {Z,C,V,N}.
REQ-004 The block SHALL have one parameter: NUM_OPS, default 10, number of legal opcodes (0..NUM_OPS-1).

Function
REQ-005 The block SHALL implement four states: IDLE, LO, HI, RESP.
REQ-006 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-007 A request SHALL be accepted on an edge where req_valid=1 in IDLE; op, wide, use_c, a and b SHALL be registered on that edge.
REQ-008 A request SHALL be illegal when op>=NUM_OPS, or when wide=1 and op is not ADD(0) or SUB(1).
REQ-009 An illegal request SHALL go IDLE->RESP with resp_err=1 and resp_result=0, leave flags_q unchanged, and drive no ALU pass.
REQ-010 A legal single op SHALL go IDLE->LO->RESP.
- LO drives the ALU with a[7:0], b[7:0], op, and cin = use_c ? flags_q.C : 0.
- resp_result = {8'h00, alu_result}.
- Flags are taken directly from the ALU.
REQ-011 A legal wide op SHALL go IDLE->LO->HI->RESP.
- LO pass: low bytes; the low result and low carry are registered.
- HI pass: high bytes, cin = low carry.
- resp_result = {hi, lo}.
REQ-012 For wide ops, Z SHALL be (lo==0 && hi==0); C, V and N SHALL come from the HI pass.
REQ-013 For SUB, C=1 SHALL mean borrow, and the ALU SHALL compute a-b-cin.
REQ-014 flags_q SHALL update on the edge that enters RESP for legal ops only.
REQ-015 Latency:
- single op: resp_valid is high the second cycle after the accepting edge;
- wide op: the third cycle;
- illegal op: the next cycle.
REQ-016 In RESP, resp_valid SHALL be 1, and resp_result and resp_err SHALL be held stable until resp_ready=1; RESP->IDLE occurs on that edge.
REQ-017 A req_valid asserted outside IDLE SHALL be ignored and SHALL NOT be lost by the requester, because ready is low.
REQ-018 ALU input ports SHALL be driven to 0 (opcode 0, cin 0) in IDLE and RESP.

Reset
REQ-019 While rst_n=0 at a rising edge, the state SHALL become IDLE and flags_q SHALL become 0000.
REQ-020 While rst_n=0 at a rising edge, resp_valid, resp_err and resp_result SHALL become 0, and all operand registers SHALL be cleared.
REQ-021 Reset asserted in LO, HI or RESP SHALL abort the operation with no response and no flag update.

Structure
REQ-022 The opcode constants SHALL live in the shared package alu_pkg: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOT=5, LAND=6, LOR=7, LXOR=8, LNOT=9.
REQ-023 The state encoding and the flag bit indices Z=3, C=2, V=1, N=0 SHALL also live in alu_pkg.
REQ-024 The block SHALL instantiate exactly one sub-module, the existing combinational 8-bit ALU full_adder (a, b, opcode, cin -> result, zero, carry, overflow, negative).

Verification
REQ-025 Reset: hold rst_n=0 for 2 cycles -> req_ready=1, resp_valid=0, flags_q=0000.
REQ-026 Single ADD: a=0x007F, b=0x0001 -> after 2 cycles resp_result=0x0080, flags_q Z=0 C=0 V=1 N=1.
REQ-027 Wide ops:
- ADD 0x00FF+0x0001 -> 0x0100, Z=0 C=0.
- SUB 0x0100-0x0001 -> 0x00FF, C=0 N=0, resp after 3 cycles.
REQ-028 Carry chain: ADD 200+100 (C=1), then ADD 0+0 with req_use_c=1 -> resp_result=0x0001.
REQ-029 Backpressure and illegal requests:
- resp_ready=0 for 3 cycles -> result held, req_ready=0, a competing request is not accepted.
- op=0xC, or wide AND -> resp_err=1, flags_q unchanged.
REQ-030 Reset mid-operation: rst_n=0 during HI of a wide ADD -> IDLE next cycle, no resp_valid, flags_q=0000.
